// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer that time-shares one external N-bit rca,
// walking WORDS slices LSB-first and chaining the carry between them.
module rca_seq_ctrl #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 sub,
  output logic [N-1:0]         rca_A,
  output logic [N-1:0]         rca_B,
  output logic                 rca_Cin,
  input  logic [N-1:0]         rca_S,
  input  logic                 rca_Cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   result,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;

  assign in_ready = (state == IDLE) && !RESET;

  // Slice select is a decoded mux so it stays clean for non-power-of-two WORDS.
  always_comb begin
    rca_A   = '0;
    rca_B   = '0;
    rca_Cin = 1'b0;
    if (state == RUN) begin
      rca_Cin = carry_reg;
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (idx == IDX_W'(i)) begin
          rca_A = a_reg[i*N +: N];
          rca_B = b_reg[i*N +: N];
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_reg <= sub;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
              result[i*N +: N] <= rca_S;
            end
          end
          carry_reg <= rca_Cout;
          if (idx == LAST) begin
            carry_out <= rca_Cout;
            // b_reg holds the already-inverted subtrahend, so one rule covers add and sub.
            overflow  <= (a_reg[W-1] == b_reg[W-1]) && (rca_S[N-1] != a_reg[W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with a behavioural 8-bit rca attached.
module tb_rca_seq_ctrl;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic          CLOCK_50 = 1'b0;
  logic          RESET;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          sub;
  logic [N-1:0]  rca_A;
  logic [N-1:0]  rca_B;
  logic          rca_Cin;
  logic [N-1:0]  rca_S;
  logic          rca_Cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  assign {rca_Cout, rca_S} = {1'b0, rca_A} + {1'b0, rca_B} + {{N{1'b0}}, rca_Cin};

  rca_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .rca_A     (rca_A),
    .rca_B     (rca_B),
    .rca_Cin   (rca_Cin),
    .rca_S     (rca_S),
    .rca_Cout  (rca_Cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Accepts one operation and waits for out_valid; leaves the block in DONE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_res, input logic exp_c,
                        input logic exp_v, output logic [3:0] cin_trace);
    int cyc;
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid  = 1'b0;
    op_a      = '1;
    op_b      = '1;
    sub       = ~s;
    cyc       = 0;
    cin_trace = '0;
    while (!out_valid && cyc < 20) begin
      if (cyc < 4) cin_trace[cyc] = rca_Cin;
      tick();
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'd4);
    check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
    check_eq({tag, "_carry"}, 64'(carry_out), 64'(exp_c));
    check_eq({tag, "_ovf"}, 64'(overflow), 64'(exp_v));
    check_eq({tag, "_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_vdrop"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [3:0]   trace;
    logic [W-1:0] held;
    int           acc_cyc[$];
    int           wait_cyc;

    RESET     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    #12;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_carry", 64'(carry_out), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    check_eq("rst_rca", 64'({rca_A, rca_B, rca_Cin}), 64'd0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    tick();

    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, trace);
    check_eq("add_wrap_cin_trace", 64'(trace), 64'b1110);
    release_op("add_wrap");

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, trace);
    release_op("add_ovf");

    run_op("sub_neg", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, trace);
    check_eq("sub_neg_cin_trace", 64'(trace[0]), 64'd1);
    release_op("sub_neg");

    run_op("sub_pos", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, trace);
    release_op("sub_pos");

    run_op("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, trace);

    // Backpressure: hold DONE for 10 cycles while poking in_valid.
    held = result;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      check_eq("bp_valid", 64'(out_valid), 64'd1);
      check_eq("bp_result", 64'(result), 64'(held));
      check_eq("bp_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    release_op("bp");
    check_eq("bp_result_kept", 64'(result), 64'(held));

    // Back-to-back: in_valid and out_ready both held high.
    op_a      = 32'h0000_0100;
    op_b      = 32'h0000_0203;
    sub       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_valid && in_ready) acc_cyc.push_back(c);
      tick();
    end
    in_valid = 1'b0;
    check_eq("b2b_accepts", 64'(acc_cyc.size()), 64'd4);
    if (acc_cyc.size() >= 3) begin
      check_eq("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
      check_eq("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);
    end
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    check_eq("b2b_drained", 64'(in_ready), 64'd1);
    check_eq("b2b_result", 64'(result), 64'h0000_0303);
    out_ready = 1'b0;

    // Reset in the middle of RUN at idx=2.
    op_a     = 32'hAAAA_AAAA;
    op_b     = 32'h5555_5555;
    sub      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("mid_rca_A", 64'(rca_A), 64'hAA);
    RESET = 1'b1;
    #1;
    check_eq("mid_rst_rca", 64'({rca_A, rca_B, rca_Cin}), 64'd0);
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_ready", 64'(in_ready), 64'd0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    tick();
    check_eq("post_rst_valid", 64'(out_valid), 64'd0);
    run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, trace);
    release_op("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
